// File: rtl/oversampling_pkg.sv
// Shared types and elaboration helpers for the oversampling edge detector.
package oversampling_pkg;

  localparam int MAX_IDX_W       = 8;
  localparam int DEFAULT_TS_BITS = 16;

  typedef struct packed {
    logic                 flag;
    logic [MAX_IDX_W-1:0] index;
  } prio_node_t;

  function automatic bit width_is_legal(int w);
    return (w == 16) || (w == 64) || (w == 256);
  endfunction

  function automatic int clog4(int w);
    int levels;
    int span;
    levels = 0;
    span   = 1;
    while (span < w) begin
      span   = span * 4;
      levels = levels + 1;
    end
    return levels;
  endfunction

  // Start position of tree level lv (1 = leaf groups) in the flat node array.
  function automatic int level_offset(int w, int lv);
    int off;
    off = 0;
    for (int k = 1; k < lv; k++) begin
      off = off + (w >> (2 * k));
    end
    return off;
  endfunction

endpackage

// File: rtl/oversampling_prio_node.sv
// Registered radix-4 priority merge: lowest flagged child wins, its number
// is prefixed to the child's index.
module oversampling_prio_node
  import oversampling_pkg::*;
#(
  parameter int CHILD_IDX_W = 0
) (
  input  logic             CLK_PARALLEL,
  input  logic             RESET_N,
  input  logic             valid,
  input  prio_node_t [3:0] child,
  output prio_node_t       node
);

  logic [1:0]           sel;
  logic                 any;
  logic [MAX_IDX_W-1:0] idx_next;

  always_comb begin
    sel = 2'd0;
    any = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (child[k].flag) begin
        sel = 2'(k);
        any = 1'b1;
      end
    end
  end

  assign idx_next = (MAX_IDX_W'(sel) << CHILD_IDX_W) | child[sel].index;

  always_ff @(posedge CLK_PARALLEL or negedge RESET_N) begin
    if (!RESET_N) begin
      node <= '0;
    end else begin
      node.flag  <= valid & any;
      node.index <= idx_next;
    end
  end

endmodule

// File: rtl/oversampling_edge_detector.sv
// First-edge detector for oversampled ISERDES words with a pipelined radix-4
// priority tree. Define OVERSAMPLING_EDGE_COUNT_EN to add EDGE_COUNT/GLITCH.
module oversampling_edge_detector
  import oversampling_pkg::*;
#(
  parameter int WIDTH   = 64,
  parameter int TS_BITS = DEFAULT_TS_BITS,
  parameter int WARMUP  = 2
) (
  input  logic                               CLK_PARALLEL,
  input  logic                               RESET_N,
  input  logic                               CE,
  input  logic [WIDTH-1:0]                   PARALLEL_IN,
  output logic                               EDGE_VALID,
  output logic                               EDGE_RISING,
  output logic [$clog2(WIDTH)-1:0]           EDGE_BIT,
  output logic [TS_BITS+$clog2(WIDTH)-1:0]   EDGE_TIME
`ifdef OVERSAMPLING_EDGE_COUNT_EN
  ,
  output logic [$clog2(WIDTH):0]             EDGE_COUNT,
  output logic                               GLITCH
`endif
);

  localparam int LEVELS = clog4(WIDTH);
  localparam int BIT_W  = $clog2(WIDTH);
  localparam int NODES  = (WIDTH - 1) / 3;

  if (!width_is_legal(WIDTH)) begin : g_bad_width
    $error("oversampling_edge_detector: WIDTH must be 16, 64 or 256");
  end
  if (WARMUP < 1 || WARMUP > 15) begin : g_bad_warmup
    $error("oversampling_edge_detector: WARMUP must be 1..15");
  end

  logic [3:0]         warm_q;
  logic               last_q;
  logic [TS_BITS-1:0] ts_q;
  logic               accept;
  logic [WIDTH-1:0]   diff;
  logic [WIDTH-1:0]   cap_diff;

  // Stage 0 is the capture register; stage s follows tree level s.
  logic [LEVELS:0]    vld_p;
  logic [LEVELS:0]    rise_p;
  logic [TS_BITS-1:0] ts_p [LEVELS+1];

  assign accept = CE && (warm_q == 4'(WARMUP));
  assign diff   = PARALLEL_IN ^ {PARALLEL_IN[WIDTH-2:0], last_q};

  always_ff @(posedge CLK_PARALLEL or negedge RESET_N) begin
    if (!RESET_N) begin
      warm_q <= '0;
      last_q <= 1'b0;
      ts_q   <= '0;
    end else begin
      ts_q <= ts_q + 1'b1;
      if (!CE) begin
        warm_q <= '0;
      end else begin
        if (warm_q != 4'(WARMUP)) begin
          warm_q <= warm_q + 4'd1;
        end
        last_q <= PARALLEL_IN[WIDTH-1];
      end
    end
  end

  always_ff @(posedge CLK_PARALLEL or negedge RESET_N) begin
    if (!RESET_N) begin
      cap_diff <= '0;
      vld_p    <= '0;
      rise_p   <= '0;
      for (int s = 0; s <= LEVELS; s++) begin
        ts_p[s] <= '0;
      end
    end else begin
      cap_diff  <= accept ? diff : '0;
      vld_p[0]  <= accept;
      rise_p[0] <= ~last_q;
      ts_p[0]   <= ts_q;
      for (int s = 1; s <= LEVELS; s++) begin
        vld_p[s]  <= vld_p[s-1];
        rise_p[s] <= rise_p[s-1];
        ts_p[s]   <= ts_p[s-1];
      end
    end
  end

  prio_node_t [WIDTH-1:0] leaf;
  prio_node_t [NODES-1:0] tree;
  prio_node_t             root;

  always_comb begin
    leaf = '0;
    for (int i = 0; i < WIDTH; i++) begin
      leaf[i].flag = cap_diff[i];
    end
  end

  for (genvar lv = 1; lv <= LEVELS; lv++) begin : g_lvl
    localparam int CNT = WIDTH >> (2 * lv);
    localparam int OFF = level_offset(WIDTH, lv);
    for (genvar n = 0; n < CNT; n++) begin : g_node
      prio_node_t [3:0] kids;
      if (lv == 1) begin : g_leaf
        assign kids = leaf[4*n +: 4];
      end else begin : g_inner
        assign kids = tree[level_offset(WIDTH, lv-1) + 4*n +: 4];
      end
      oversampling_prio_node #(
        .CHILD_IDX_W (2 * (lv - 1))
      ) u_node (
        .CLK_PARALLEL (CLK_PARALLEL),
        .RESET_N      (RESET_N),
        .valid        (vld_p[lv-1]),
        .child        (kids),
        .node         (tree[OFF+n])
      );
    end
  end

  logic hit;
  logic unused_root_bits;

  assign root             = tree[NODES-1];
  assign hit              = vld_p[LEVELS] & root.flag;
  assign unused_root_bits = ^root.index;

  assign EDGE_VALID  = hit;
  assign EDGE_RISING = hit & rise_p[LEVELS];
  assign EDGE_BIT    = hit ? root.index[BIT_W-1:0] : '0;
  assign EDGE_TIME   = hit ? {ts_p[LEVELS], root.index[BIT_W-1:0]} : '0;

`ifdef OVERSAMPLING_EDGE_COUNT_EN
  logic [BIT_W:0] cnt_p [1:LEVELS];

  function automatic logic [BIT_W:0] popcount(logic [WIDTH-1:0] v);
    logic [BIT_W:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      c = c + {{BIT_W{1'b0}}, v[i]};
    end
    return c;
  endfunction

  // cap_diff is already zero for rejected words, so the count needs no gating here.
  always_ff @(posedge CLK_PARALLEL or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int s = 1; s <= LEVELS; s++) begin
        cnt_p[s] <= '0;
      end
    end else begin
      cnt_p[1] <= popcount(cap_diff);
      for (int s = 2; s <= LEVELS; s++) begin
        cnt_p[s] <= cnt_p[s-1];
      end
    end
  end

  assign EDGE_COUNT = hit ? cnt_p[LEVELS] : '0;
  assign GLITCH     = hit && (cnt_p[LEVELS] > 1);
`endif

endmodule

// File: tb/tb_oversampling_edge_detector.sv
// Scoreboard bench for oversampling_edge_detector (WIDTH=64, TS_BITS=4, WARMUP=2).
module tb_oversampling_edge_detector;

  localparam int W   = 64;
  localparam int TSB = 4;
  localparam int WU  = 2;
  localparam int L   = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ce = 1'b0;
  logic [W-1:0]  din = '0;
  logic          edge_valid;
  logic          edge_rising;
  logic [5:0]    edge_bit;
  logic [9:0]    edge_time;
`ifdef OVERSAMPLING_EDGE_COUNT_EN
  logic [6:0]    edge_count;
  logic          glitch;
`endif

  oversampling_edge_detector #(.WIDTH(W), .TS_BITS(TSB), .WARMUP(WU)) dut (
    .CLK_PARALLEL (clk),
    .RESET_N      (rst_n),
    .CE           (ce),
    .PARALLEL_IN  (din),
    .EDGE_VALID   (edge_valid),
    .EDGE_RISING  (edge_rising),
    .EDGE_BIT     (edge_bit),
    .EDGE_TIME    (edge_time)
`ifdef OVERSAMPLING_EDGE_COUNT_EN
    ,
    .EDGE_COUNT   (edge_count),
    .GLITCH       (glitch)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic       r;
    logic [5:0] b;
    logic [9:0] t;
    logic [6:0] c;
    logic       g;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  logic m_last;
  int   m_warm;
  int   m_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t zero_exp();
    exp_t e;
    e.v = 1'b0; e.r = 1'b0; e.b = '0; e.t = '0; e.c = '0; e.g = 1'b0;
    return e;
  endfunction

  task automatic model_push(input logic c, input logic [W-1:0] w);
    exp_t e;
    logic prev;
    int   cnt;
    int   first;
    e = zero_exp();
    if (c) begin
      if (m_warm == WU) begin
        prev  = m_last;
        cnt   = 0;
        first = 0;
        for (int i = 0; i < W; i++) begin
          if (w[i] != prev) begin
            cnt++;
            if (cnt == 1) first = i;
          end
          prev = w[i];
        end
        if (cnt > 0) begin
          e.v = 1'b1;
          e.r = ~m_last;
          e.b = 6'(first);
          e.t = {4'(m_cyc % 16), 6'(first)};
          e.c = 7'(cnt);
          e.g = (cnt > 1);
        end
      end else begin
        m_warm++;
      end
      m_last = w[W-1];
    end else begin
      m_warm = 0;
    end
    m_cyc++;
    q.push_back(e);
  endtask

  task automatic compare(input exp_t e);
    chk("edge_valid", 32'(edge_valid), 32'(e.v));
    chk("edge_rising", 32'(edge_rising), 32'(e.r));
    chk("edge_bit", 32'(edge_bit), 32'(e.b));
    chk("edge_time", 32'(edge_time), 32'(e.t));
`ifdef OVERSAMPLING_EDGE_COUNT_EN
    chk("edge_count", 32'(edge_count), 32'(e.c));
    chk("glitch", 32'(glitch), 32'(e.g));
`endif
  endtask

  // Called just after a posedge; one clock edge per call.
  task automatic step(input logic c, input logic [W-1:0] w);
    ce  = c;
    din = w;
    @(posedge clk);
    model_push(c, w);
    #1;
    if (q.size() > L) compare(q.pop_front());
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    compare(zero_exp());
    q.delete();
    for (int i = 0; i < L; i++) q.push_back(zero_exp());
    m_last = 1'b0;
    m_warm = 0;
    m_cyc  = 0;
    ce     = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic rand_word(output logic c, output logic [W-1:0] w);
    int           k;
    logic [W-1:0] mask;
    c    = ($urandom_range(0, 7) != 0);
    k    = $urandom_range(0, W-1);
    mask = (64'h1 << k) - 64'h1;
    w    = ({$urandom, $urandom} & ~mask) | (m_last ? mask : '0);
    w[k] = ~m_last;
    if ($urandom_range(0, 5) == 0) w = m_last ? '1 : '0;
  endtask

  initial begin
    logic         rc;
    logic [W-1:0] rw;
    do_reset();

    step(1'b1, 64'h0);
    step(1'b1, 64'h0);
    step(1'b1, 64'h0000_0000_0000_FF00);
    step(1'b1, '1);
    step(1'b1, '1);
    step(1'b1, 64'hFFFF_FFFF_FFFF_FFF0);
    step(1'b1, 64'h0);
    step(1'b1, 64'h8000_0000_0000_0000);
    step(1'b1, '1);
    step(1'b1, 64'h0);
    step(1'b1, 64'h0000_0000_0000_0F0F);

    step(1'b0, '1);
    for (int i = 0; i < 6; i++) step(1'b1, (i % 2) ? 64'h0 : '1);
    step(1'b0, 64'h0);
    for (int i = 0; i < 6; i++) step(1'b1, (i % 2) ? 64'h0 : '1);

    for (int i = 0; i < 40; i++) begin
      rand_word(rc, rw);
      step(rc, rw);
    end

    step(1'b1, '1);
    step(1'b1, 64'h0);
    step(1'b1, '1);
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, (i % 2) ? 64'h0 : 64'h0000_00F0_0000_0000);

    for (int i = 0; i < 25; i++) begin
      rand_word(rc, rw);
      step(1'b1, rw);
    end

    for (int i = 0; i < L + 1; i++) step(1'b0, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
